display_refresh_ctrl: RTL
=========================

// Module: display_refresh_ctrl
// PURPOSE
//  Sequencer for the serial 7-segment output path. Decides when a new frame is shifted out,
//  drives the start strobe, and honours the output path's busy handshake.
//  Merges four frame requests: time-update strobe, periodic refresh, blink-phase toggle, and mode/enable change.
//  Produces per-digit enables and colon DP for set-mode blinking.
//  Sits between clock core / button FSM and the output wrapper.
// PARAMETERS
//  SYS_CLK_HZ    50_000_000  system clock frequency
//  REFRESH_HZ    100         periodic refresh rate (frames/s, re-sends even if unchanged)
//  BLINK_HZ      2           blink rate of digits under edit (full on/off period)
//  BUSY_TIMEOUT  16          cycles to wait for i_busy to rise after a start strobe
// PORTS
//  i_clk          in   1  system clock
//  i_reset_n      in   1  asynchronous active-low reset
//  i_update_stb   in   1  1-cycle pulse: displayed time changed
//  i_set_mode     in   2  0=run, 1=set hours, 2=set minutes, 3=set seconds
//  i_display_en   in   1  0 blanks whole display
//  i_busy         in   1  output path busy, from shift-out
//  o_start_stb    out  1  1-cycle frame start to output path
//  o_display_en   out  1  frame-latched display enable
//  o_digit_en     out  6  {h_msb,h_lsb,m_msb,m_lsb,s_msb,s_lsb}; 1 = digit lit
//  o_colon_dp     out  1  DP drive for colon positions
//  o_fault        out  1  sticky: busy never rose within BUSY_TIMEOUT
// BEHAVIOUR
//  Reset values:
//   - o_start_stb=0, o_display_en=0, o_digit_en=6'h3F, o_colon_dp=0, o_fault=0
//   - blink_phase=0, state=IDLE, pending=1 (first frame goes out after reset)
//  Tick generation:
//   - refresh_tick: 1-cycle pulse every SYS_CLK_HZ/REFRESH_HZ cycles.
//   - blink_tick: 1-cycle pulse every SYS_CLK_HZ/(2*BLINK_HZ) cycles; toggles blink_phase.
//  Pending flag:
//   - Set by: i_update_stb, refresh_tick, blink_tick, i_set_mode change, i_display_en change
//     (changes detected against the previous-cycle registered copy).
//   - Requests coalesce: many requests while busy give exactly one later frame.
//   - Cleared on entry to START. A request in that same cycle re-sets it (set wins).
//  FSM:
//   - IDLE -> START when pending & !i_busy.
//   - START (1 cycle):
//     - o_start_stb=1.
//     - Latch o_display_en, o_digit_en, o_colon_dp from the current inputs and blink_phase.
//     - Then go to WAIT_ACK.
//   - WAIT_ACK -> WAIT_DONE when i_busy=1.
//     After BUSY_TIMEOUT cycles without busy: set o_fault, go to IDLE; pending remains set.
//   - WAIT_DONE -> IDLE when i_busy=0.
//   - Latency: pending request to o_start_stb is 1 cycle when idle and not busy.
//  Frame outputs: held constant from START until the next START, so a frame is never torn.
//  Digit enables:
//   - mode0: 6'h3F
//   - mode1: bits[5:4]=blink_phase, others 1
//   - mode2: bits[3:2]=blink_phase, others 1
//   - mode3: bits[1:0]=blink_phase, others 1
//  o_colon_dp: blink_phase in mode0 (1 Hz-style pulse); constant 1 in set modes.
//  Reset mid-frame: asynchronous return to reset values. The output path is reset by the same i_reset_n.
//  Counter widths come from $clog2 of the divide ratios. Require REFRESH_HZ, 2*BLINK_HZ <= SYS_CLK_HZ.
// STRUCTURE
//  - Shared include clock_defs.vh:
//    - MODE_RUN/MODE_SET_H/MODE_SET_M/MODE_SET_S encodings
//    - FSM state localparams IDLE/START/WAIT_ACK/WAIT_DONE
//  - Sub-module: two existing sysclk_divider instances.
//    - Refresh: OUT_CLK_HZ=REFRESH_HZ.
//    - Blink: OUT_CLK_HZ=2*BLINK_HZ.
//    - Their o_clk_overflow outputs are used as the ticks.
// TESTING  (SYS_CLK_HZ=1000, REFRESH_HZ=10, BLINK_HZ=1; refresh 100 cyc, blink toggle 500 cyc)
//  1. Release reset, i_busy=0 -> o_start_stb at cycle 1.
//     Model busy high 20 cycles -> next o_start_stb at the first refresh tick (~cycle 100).
//  2. i_update_stb x3 while busy high for 40 cycles -> exactly one o_start_stb, 1 cycle after busy falls.
//  3. i_set_mode=1 -> frame within 2 cycles with o_digit_en=6'h0F or 6'h3F (per phase).
//     Alternates at each 500-cycle blink frame. o_colon_dp=1.
//  4. i_busy stuck 0 after start -> o_fault=1 after 16 cycles.
//     FSM back to IDLE, restarts on next cycle, o_fault stays 1.
//  5. i_display_en 1->0 -> frame with o_display_en=0 within 2 cycles.
//     o_digit_en unchanged between starts.
//  6. Assert i_reset_n=0 during WAIT_DONE -> all outputs return to reset values immediately, no clock needed.

Source files
------------

// File: rtl/display_refresh_ctrl_pkg.sv
// rtl/display_refresh_ctrl_pkg.sv - shared encodings and digit-mask helpers for the refresh sequencer
package display_refresh_ctrl_pkg;

  localparam logic [1:0] MODE_RUN   = 2'd0;
  localparam logic [1:0] MODE_SET_H = 2'd1;
  localparam logic [1:0] MODE_SET_M = 2'd2;
  localparam logic [1:0] MODE_SET_S = 2'd3;

  localparam logic [5:0] DIGITS_ALL_ON = 6'h3F;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  // The digit pair under edit follows the blink phase; all others stay lit.
  function automatic logic [5:0] digit_mask(input logic [1:0] mode, input logic phase);
    logic [5:0] m;
    m = DIGITS_ALL_ON;
    case (mode)
      MODE_SET_H: m[5:4] = {2{phase}};
      MODE_SET_M: m[3:2] = {2{phase}};
      MODE_SET_S: m[1:0] = {2{phase}};
      default:    m      = DIGITS_ALL_ON;
    endcase
    return m;
  endfunction

  // Colon pulses with the blink phase while running, solid while editing.
  function automatic logic colon_drive(input logic [1:0] mode, input logic phase);
    return (mode == MODE_RUN) ? phase : 1'b1;
  endfunction

endpackage

// File: rtl/display_refresh_ctrl_if.sv
// rtl/display_refresh_ctrl_if.sv - request/handshake and frame-output bundle of the refresh sequencer
interface display_refresh_ctrl_if;

  logic       i_update_stb;
  logic [1:0] i_set_mode;
  logic       i_display_en;
  logic       i_busy;
  logic       o_start_stb;
  logic       o_display_en;
  logic [5:0] o_digit_en;
  logic       o_colon_dp;
  logic       o_fault;

  // Sequencer side: consumes requests and busy, drives the frame.
  modport master (
    input  i_update_stb, i_set_mode, i_display_en, i_busy,
    output o_start_stb, o_display_en, o_digit_en, o_colon_dp, o_fault
  );

  // Environment side: clock core, button FSM and output path.
  modport slave (
    output i_update_stb, i_set_mode, i_display_en, i_busy,
    input  o_start_stb, o_display_en, o_digit_en, o_colon_dp, o_fault
  );

endinterface

// File: rtl/sysclk_divider.sv
// rtl/sysclk_divider.sv - free-running divider emitting a one-cycle overflow pulse per output period
module sysclk_divider #(
  parameter int SYS_CLK_HZ = 50_000_000,
  parameter int OUT_CLK_HZ = 100
) (
  input  logic i_clk,
  input  logic i_reset_n,
  output logic o_clk_overflow
);

  localparam int RATIO_RAW = SYS_CLK_HZ / OUT_CLK_HZ;
  localparam int RATIO     = (RATIO_RAW < 1) ? 1 : RATIO_RAW;
  localparam int CW        = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrap at the last count so the pulse period is exactly RATIO cycles.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign o_clk_overflow = (cnt_q == CNT_LAST);

endmodule

// File: rtl/display_refresh_ctrl.sv
// rtl/display_refresh_ctrl.sv - frame sequencer for the serial 7-segment output path
module display_refresh_ctrl
  import display_refresh_ctrl_pkg::*;
#(
  parameter int SYS_CLK_HZ   = 50_000_000,
  parameter int REFRESH_HZ   = 100,
  parameter int BLINK_HZ     = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  display_refresh_ctrl_if.master  bus
);

  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(BUSY_TIMEOUT - 1);

  logic          refresh_tick, blink_tick;
  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          pending_q, pending_d;
  logic          blink_phase_q;
  logic [1:0]    mode_prev_q;
  logic          en_prev_q;
  logic          go, timeout, start_stb, req;
  logic          disp_en_q, colon_q, fault_q;
  logic [5:0]    digit_en_q;

  sysclk_divider #(.SYS_CLK_HZ(SYS_CLK_HZ), .OUT_CLK_HZ(REFRESH_HZ)) u_refresh_div (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .o_clk_overflow(refresh_tick)
  );

  sysclk_divider #(.SYS_CLK_HZ(SYS_CLK_HZ), .OUT_CLK_HZ(2 * BLINK_HZ)) u_blink_div (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .o_clk_overflow(blink_tick)
  );

  // Any reason to resend; mode/enable changes compare against last cycle's copy.
  assign req = bus.i_update_stb | refresh_tick | blink_tick
             | (bus.i_set_mode != mode_prev_q) | (bus.i_display_en != en_prev_q);

  // Next-state logic: start handshake, busy acknowledge with timeout, busy completion.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    go        = 1'b0;
    timeout   = 1'b0;
    start_stb = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q && !bus.i_busy) begin
          go      = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        start_stb = 1'b1;
        tmr_d     = '0;
        state_d   = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (bus.i_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (tmr_q == TMR_LAST) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.i_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new request always wins over the clear that accompanies a frame launch.
  always_comb begin
    pending_d = pending_q;
    if (req || timeout) pending_d = 1'b1;
    else if (go)        pending_d = 1'b0;
  end

  // FSM, timer, request tracking and blink phase registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      tmr_q         <= '0;
      pending_q     <= 1'b1;
      blink_phase_q <= 1'b0;
      mode_prev_q   <= MODE_RUN;
      en_prev_q     <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      pending_q   <= pending_d;
      mode_prev_q <= bus.i_set_mode;
      en_prev_q   <= bus.i_display_en;
      if (blink_tick) blink_phase_q <= ~blink_phase_q;
      if (timeout)    fault_q       <= 1'b1;
    end
  end

  // Frame contents are captured only on launch so a frame in flight is never torn.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      disp_en_q  <= 1'b0;
      digit_en_q <= DIGITS_ALL_ON;
      colon_q    <= 1'b0;
    end else if (go) begin
      disp_en_q  <= bus.i_display_en;
      digit_en_q <= digit_mask(bus.i_set_mode, blink_phase_q);
      colon_q    <= colon_drive(bus.i_set_mode, blink_phase_q);
    end
  end

  assign bus.o_start_stb  = start_stb;
  assign bus.o_display_en = disp_en_q;
  assign bus.o_digit_en   = digit_en_q;
  assign bus.o_colon_dp   = colon_q;
  assign bus.o_fault      = fault_q;

endmodule
